// File: rtl/ibex_noc_arbiter.sv
// Round-robin arbiter that serialises per-core messages onto one NoC egress link.
// Ports: clk_i/rst_ni, req_i/gnt_o plus per-requester len/data/addr/core fields,
// noc_* flit stream (valid/ready, data, head, last, src) and busy_o.
// Optional IBEX_NOC_ARB_STATS_EN adds msg_count_o / stall_count_o (saturating).
module ibex_noc_arbiter #(
  parameter int NumReq = 4,
  parameter int SrcW   = $clog2(NumReq)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_i,
  output logic [NumReq-1:0]             gnt_o,
  input  logic [NumReq-1:0][1:0]        len_i,
  input  logic [NumReq-1:0][3:0][31:0]  data_i,
  input  logic [NumReq-1:0][15:0]       addr_i,
  input  logic [NumReq-1:0][15:0]       core_i,
  output logic                          noc_valid_o,
  input  logic                          noc_ready_i,
  output logic [31:0]                   noc_data_o,
  output logic                          noc_head_o,
  output logic                          noc_last_o,
  output logic [SrcW-1:0]               noc_src_o,
  output logic                          busy_o
`ifdef IBEX_NOC_ARB_STATS_EN
  ,
  output logic [31:0]                   msg_count_o,
  output logic [31:0]                   stall_count_o
`endif
);

  typedef enum logic [1:0] {
    Idle,
    Head,
    Payload
  } state_e;

  state_e state_q, state_d;

  logic [SrcW-1:0]  rr_q;
  logic [SrcW-1:0]  win;
  logic [SrcW-1:0]  rr_nxt;
  logic             any_req;
  logic             grant_ev;
  logic             is_last;

  logic [1:0]       len_q;
  logic [3:0][31:0] words_q;
  logic [15:0]      addr_q;
  logic [15:0]      core_q;
  logic [SrcW-1:0]  src_q;
  logic [1:0]       idx_q;

  function automatic logic [SrcW-1:0] rr_idx(
    input logic [SrcW-1:0] base,
    input int              off
  );
    int s;
    s = int'(base) + off;
    if (s >= NumReq) s = s - NumReq;
    return SrcW'(s);
  endfunction

  // First pending requester at or after rr_q, wrapping past the top.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (!any_req && req_i[rr_idx(rr_q, i)]) begin
        any_req = 1'b1;
        win     = rr_idx(rr_q, i);
      end
    end
  end

  assign rr_nxt   = (win == SrcW'(NumReq - 1)) ? '0 : win + SrcW'(1);
  assign grant_ev = (state_q == Idle) && any_req;
  assign is_last  = (idx_q == len_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Idle:    if (any_req) state_d = Head;
      Head:    if (noc_ready_i) state_d = Payload;
      Payload: if (noc_ready_i && is_last) state_d = Idle;
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q    <= '0;
      len_q   <= '0;
      words_q <= '0;
      addr_q  <= '0;
      core_q  <= '0;
      src_q   <= '0;
      idx_q   <= '0;
    end else if (grant_ev) begin
      rr_q    <= rr_nxt;
      len_q   <= len_i[win];
      words_q <= data_i[win];
      addr_q  <= addr_i[win];
      core_q  <= core_i[win];
      src_q   <= win;
      idx_q   <= '0;
    end else if (state_q == Head && noc_ready_i) begin
      idx_q   <= '0;
    end else if (state_q == Payload && noc_ready_i && !is_last) begin
      idx_q   <= idx_q + 2'd1;
    end
  end

  // Grant is gated by reset so nothing is captured while held in reset.
  always_comb begin
    gnt_o       = '0;
    noc_valid_o = 1'b0;
    noc_head_o  = 1'b0;
    noc_last_o  = 1'b0;
    noc_data_o  = '0;
    noc_src_o   = '0;
    busy_o      = 1'b0;
    if (grant_ev && rst_ni) gnt_o[win] = 1'b1;
    unique case (state_q)
      Head: begin
        noc_valid_o = 1'b1;
        noc_head_o  = 1'b1;
        noc_data_o  = {core_q, addr_q};
        noc_src_o   = src_q;
        busy_o      = 1'b1;
      end
      Payload: begin
        noc_valid_o = 1'b1;
        noc_last_o  = is_last;
        noc_data_o  = words_q[idx_q];
        noc_src_o   = src_q;
        busy_o      = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef IBEX_NOC_ARB_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      msg_count_o   <= '0;
      stall_count_o <= '0;
    end else begin
      if (noc_valid_o && noc_ready_i && noc_last_o &&
          msg_count_o != 32'hFFFF_FFFF)
        msg_count_o <= msg_count_o + 32'd1;
      if (noc_valid_o && !noc_ready_i &&
          stall_count_o != 32'hFFFF_FFFF)
        stall_count_o <= stall_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/ibex_noc_arbiter.md
IBEX_NOC_ARBITER -- requirements
Module: ibex_noc_arbiter

Interface
REQ-001 Parameter NumReq, default 4, number of requesting cores sharing one NoC egress link (2..16).
REQ-002 Parameter SrcW, default $clog2(NumReq), width of the source index.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 req_i  input  NumReq  per-requester message pending.
REQ-006 gnt_o  output  NumReq  per-requester capture strobe, one-hot or zero.
REQ-007 len_i  input  NumReq x 2  per-requester payload length code; payload words = code+1.
REQ-008 data_i  input  NumReq x 4 x 32  per-requester payload words 0..3 (data, msg1, msg2, msg3).
REQ-009 addr_i  input  NumReq x 16  per-requester destination address.
REQ-010 core_i  input  NumReq x 16  per-requester destination core.
REQ-011 noc_valid_o  output  1  flit valid toward NoC.
REQ-012 noc_ready_i  input  1  NoC accepts flit.
REQ-013 noc_data_o  output  32  flit contents.
REQ-014 noc_head_o  output  1  flit is header.
REQ-015 noc_last_o  output  1  flit is final payload word.
REQ-016 noc_src_o  output  SrcW  index of requester owning current message.
REQ-017 busy_o  output  1  message buffered or in flight.

Function
REQ-018 States IDLE, HEAD, PAYLOAD; single message buffer (len, 4 words, addr, core, src).
REQ-019 IDLE with any req_i: gnt_o asserts combinationally for winner that cycle; winner = first set req_i at or after rr_ptr, scanning upward with wrap NumReq-1 -> 0.
REQ-020 On grant edge: buffer loads winner fields, rr_ptr <= winner+1 mod NumReq, state -> HEAD; gnt_o zero in HEAD and PAYLOAD.
REQ-021 Requester holds req_i and fields stable until its gnt_o; deasserting req_i before grant has no effect; req_i still high after grant is a new message.
REQ-022 HEAD: noc_valid_o=1, noc_head_o=1, noc_data_o={core[15:0], addr[15:0]}; noc_ready_i -> PAYLOAD, word index 0.
REQ-023 PAYLOAD: noc_valid_o=1, noc_data_o=word[idx], noc_last_o=(idx==len); ready & !last -> idx+1; ready & last -> IDLE.
REQ-024 noc_valid_o low only in IDLE; while valid & !ready all flit outputs hold stable.
REQ-025 Latency: grant cycle to header valid = 1 cycle; minimum message occupancy = len+3 cycles (grant, head, len+1 payload); one IDLE cycle between messages.
REQ-026 noc_src_o = buffered src in HEAD/PAYLOAD, 0 in IDLE; busy_o = (state != IDLE).
REQ-027 len code 0 -> one payload word, last asserted on word 0; code 3 -> four words.

Reset
REQ-028 rst_ni low: state IDLE, rr_ptr 0, buffer 0, idx 0, all outputs 0 (gnt_o 0 while reset asserted), regardless of message in flight.
REQ-029 Reset mid-message discards the remainder; no partial flit sequence resumes after release.

Configuration
REQ-030 Macro IBEX_NOC_ARB_STATS_EN defined: adds outputs msg_count_o[31:0] (increments on ready & last) and stall_count_o[31:0] (increments on valid & !ready), both saturating at 32'hFFFF_FFFF, reset to 0.
REQ-031 Macro undefined: those ports and counters absent; all other behaviour identical.

Verification
REQ-032 req_i=4'b0010, len 1, core 16'h0003, addr 16'h0040, ready=1 -> gnt_o=4'b0010, next cycle header 32'h0003_0040 src 1, then 2 payload words, last on second.
REQ-033 req_i=4'b1111 held, len 0, ready=1 -> grant order 0,1,2,3,0 each 3 cycles apart.
REQ-034 rr_ptr=3, req_i=4'b1001 -> requester 3 wins, rr_ptr wraps to 0, requester 0 next.
REQ-035 ready low 5 cycles during payload word 2 of len 3 -> noc_data_o and noc_last_o stable; with IBEX_NOC_ARB_STATS_EN stall_count_o=5, msg_count_o=1 at end.
REQ-036 rst_ni pulsed low during PAYLOAD idx 1 -> outputs 0 immediately, after release IDLE, rr_ptr 0, next grant goes to lowest pending requester.
